// File: rtl/rsd_mem_arbiter.sv
// Round-robin arbiter sharing one memory port between IC (read-only) and DC (read/write).
// Optional RSD_MEM_ARB_STATS_EN adds saturating grant and stall counters.
module rsd_mem_arbiter #(
  parameter int MAX_OUTSTANDING = 4,
  parameter int ADDR_W          = 32,
  parameter int DATA_W          = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ic_req_i,
  input  logic [ADDR_W-1:0] ic_addr_i,
  output logic              ic_gnt_o,
  output logic              ic_rvalid_o,
  output logic [DATA_W-1:0] ic_rdata_o,
  input  logic              dc_req_i,
  input  logic              dc_we_i,
  input  logic [ADDR_W-1:0] dc_addr_i,
  input  logic [DATA_W-1:0] dc_wdata_i,
  output logic              dc_gnt_o,
  output logic              dc_rvalid_o,
  output logic [DATA_W-1:0] dc_rdata_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  output logic              mem_re_o,
  output logic              mem_we_o,
  input  logic              mem_busy_i,
  input  logic              mem_rd_valid_i,
  input  logic [DATA_W-1:0] mem_rd_data_i,
  input  logic [1:0]        mem_rd_serial_i,
  output logic [2:0]        outstanding_o,
  output logic              err_o
`ifdef RSD_MEM_ARB_STATS_EN
  ,
  output logic [31:0]       ic_grants_o,
  output logic [31:0]       dc_grants_o,
  output logic [31:0]       stall_cycles_o
`endif
);

  localparam logic [2:0] MAX_CNT = 3'(MAX_OUTSTANDING);

  logic       rr_dc;      // 1: DC holds round-robin priority
  logic [1:0] serial;
  logic [3:0] own_vld;
  logic [3:0] own_dc;
  logic [2:0] count;

  logic resp_hit, read_ok, ic_elig, dc_elig, rd_issue, slot_busy;
  logic [2:0] count_nxt;

  always_comb begin
    resp_hit = mem_rd_valid_i && own_vld[mem_rd_serial_i];
    // A full table can still take a read when a response frees an entry this cycle.
    read_ok  = !rst && !mem_busy_i &&
               ((count < MAX_CNT) || ((count == MAX_CNT) && resp_hit));
    ic_elig  = ic_req_i && read_ok;
    dc_elig  = dc_req_i && (dc_we_i ? (!rst && !mem_busy_i) : read_ok);
    ic_gnt_o = ic_elig && (!dc_elig || !rr_dc);
    dc_gnt_o = dc_elig && (!ic_elig || rr_dc);
    rd_issue = ic_gnt_o || (dc_gnt_o && !dc_we_i);
    // Entry still owned unless the response in this same cycle frees it.
    slot_busy = own_vld[serial] && !(resp_hit && (mem_rd_serial_i == serial));
    count_nxt = count + {2'b00, rd_issue} - {2'b00, resp_hit};
  end

  assign outstanding_o = count;

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_dc       <= 1'b0;
      serial      <= 2'd0;
      own_vld     <= '0;
      own_dc      <= '0;
      count       <= '0;
      err_o       <= 1'b0;
      mem_re_o    <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      ic_rvalid_o <= 1'b0;
      dc_rvalid_o <= 1'b0;
      ic_rdata_o  <= '0;
      dc_rdata_o  <= '0;
    end else begin
      mem_re_o <= rd_issue;
      mem_we_o <= dc_gnt_o && dc_we_i;
      if (ic_gnt_o) begin
        mem_addr_o <= ic_addr_i;
      end else if (dc_gnt_o) begin
        mem_addr_o <= dc_addr_i;
        if (dc_we_i) mem_wdata_o <= dc_wdata_i;
      end
      if (ic_elig && dc_elig) rr_dc <= !rr_dc;

      ic_rvalid_o <= resp_hit && !own_dc[mem_rd_serial_i];
      dc_rvalid_o <= resp_hit &&  own_dc[mem_rd_serial_i];
      if (resp_hit && !own_dc[mem_rd_serial_i]) ic_rdata_o <= mem_rd_data_i;
      if (resp_hit &&  own_dc[mem_rd_serial_i]) dc_rdata_o <= mem_rd_data_i;
      if (resp_hit) own_vld[mem_rd_serial_i] <= 1'b0;

      // Allocation follows the free so a recycled entry takes the new owner.
      if (rd_issue) begin
        own_vld[serial] <= 1'b1;
        own_dc[serial]  <= dc_gnt_o;
        serial          <= serial + 2'd1;
      end
      count <= count_nxt;

      if ((mem_rd_valid_i && !resp_hit) || (rd_issue && slot_busy)) err_o <= 1'b1;
    end
  end

`ifdef RSD_MEM_ARB_STATS_EN
  logic stall;
  assign stall = (ic_req_i || dc_req_i) && !ic_gnt_o && !dc_gnt_o;

  always_ff @(posedge clk) begin
    if (rst) begin
      ic_grants_o    <= '0;
      dc_grants_o    <= '0;
      stall_cycles_o <= '0;
    end else begin
      if (ic_gnt_o && (ic_grants_o != '1)) ic_grants_o <= ic_grants_o + 32'd1;
      if (dc_gnt_o && (dc_grants_o != '1)) dc_grants_o <= dc_grants_o + 32'd1;
      if (stall && (stall_cycles_o != '1)) stall_cycles_o <= stall_cycles_o + 32'd1;
    end
  end
`endif

endmodule

// File: doc/rsd_mem_arbiter.md
Name: rsd_mem_arbiter

Overview:
- Shares the single core-side memory port (address / write data / RE / WE, read-data return with serial) between two requesters: IC (read-only, instruction fetch) and DC (read/write, data cache).
- Round-robin arbitration; one registered command per cycle to memory.
- Tracks outstanding reads by 2-bit serial and routes each returned read to the requester that issued it.

Parameters:
- MAX_OUTSTANDING, 4, maximum in-flight reads; legal range 1..4 (serial space is 2 bits).
- ADDR_W, 32, address width.
- DATA_W, 64, memory entry width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- ic_req_i  in  1  IC read request
- ic_addr_i  in  ADDR_W  IC read address
- ic_gnt_o  out  1  IC request accepted this cycle
- ic_rvalid_o  out  1  IC read data valid
- ic_rdata_o  out  DATA_W  IC read data
- dc_req_i  in  1  DC request
- dc_we_i  in  1  DC request is a write (1) or read (0)
- dc_addr_i  in  ADDR_W  DC address
- dc_wdata_i  in  DATA_W  DC write data
- dc_gnt_o  out  1  DC request accepted this cycle
- dc_rvalid_o  out  1  DC read data valid
- dc_rdata_o  out  DATA_W  DC read data
- mem_addr_o  out  ADDR_W  memory address
- mem_wdata_o  out  DATA_W  memory write data
- mem_re_o  out  1  memory read strobe
- mem_we_o  out  1  memory write strobe
- mem_busy_i  in  1  memory cannot accept a command
- mem_rd_valid_i  in  1  memory read data ready
- mem_rd_data_i  in  DATA_W  memory read data
- mem_rd_serial_i  in  2  serial of returned read
- outstanding_o  out  3  current in-flight read count
- err_o  out  1  sticky protocol error

Behaviour:
- Reset: all outputs 0, rr pointer = IC, serial counter = 0, owner table invalid, count = 0, err = 0.
- Eligibility (combinational):
  - A read is eligible iff mem_busy_i = 0 and (count < MAX_OUTSTANDING, or count == MAX_OUTSTANDING with a valid response arriving the same cycle).
  - A DC write is eligible iff mem_busy_i = 0.
- Arbitration:
  - Only one eligible requester: it wins.
  - Both eligible: the rr pointer holder wins; pointer then moves to the loser.
  - Pointer changes only on a contested grant.
- gnt is combinational, asserted in the same cycle as req. At most one gnt per cycle. Requesters must hold req/addr/data stable until gnt.
- Issue: cycle after a grant, mem_re_o or mem_we_o is high for exactly 1 cycle, with registered addr/wdata. Otherwise both strobes = 0; addr/wdata hold their last values.
- Read issue side effects:
  - owner[serial] <= {valid=1, id}; serial <= serial+1, wrapping 3->0; count +1.
  - The serial is assigned at grant time and matches the memory's read-serial order.
- Writes: occupy no table entry; serial and count unchanged.
- Response handling:
  - On mem_rd_valid_i, look up owner[mem_rd_serial_i].
  - Valid entry: the owner's rvalid_o = 1 and rdata_o = mem_rd_data_i the next cycle (1-cycle latency); entry invalidated; count -1.
  - Invalid entry: response dropped, no rvalid, err_o set (sticky until rst).
  - rvalid is a single-cycle pulse; rdata holds its value until the next response.
- Issue and response in the same cycle: count unchanged; a table entry freed and reallocated in the same cycle takes the new owner.
- Out-of-order responses: supported via the serial lookup.
- Issue into a still-valid entry (only possible via wrap misuse): err_o set; entry overwritten.
- Reset mid-operation: table, count and pointer cleared. Responses arriving after reset for pre-reset serials hit invalid entries and set err_o.

Optional Feature:
- RSD_MEM_ARB_STATS_EN defined: adds outputs ic_grants_o[31:0], dc_grants_o[31:0] and stall_cycles_o[31:0].
  - stall_cycles_o counts cycles with at least one req and no gnt.
  - All three saturate at 0xFFFFFFFF and clear on rst.
- Not defined: these ports and counters are absent; all other behaviour identical.

Test Plan:
- Single IC read at 0x1000, mem returns serial 0 two cycles later with data 0xDEADBEEF_CAFEF00D -> ic_gnt in cycle 0, mem_re in cycle 1, ic_rvalid with that data one cycle after mem_rd_valid, outstanding back to 0.
- IC and DC reads held high for 4 cycles -> grants alternate IC, DC, IC, DC; serials 0..3 owned IC, DC, IC, DC.
- 4 reads issued without responses, 5th IC req -> no gnt while outstanding=4. Response with serial 2 in the same cycle -> gnt; new entry uses serial 0 (wrapped); outstanding stays 4.
- Responses returned in order 3, 1, 0, 2 -> each routed to its recorded owner; err_o stays 0.
- DC write to 0x2000 data 0x1234 with mem_busy_i=1 for 3 cycles -> no gnt until busy drops; then gnt, one-cycle mem_we_o, outstanding unchanged.
- mem_rd_valid_i with serial 1 and no outstanding reads -> no rvalid, err_o=1 until rst; rst for 1 cycle mid-traffic -> all outputs and counters 0.
